// File: rtl/control_switch_pkg.sv
// control_switch_pkg: accessory controller states and command-word field offsets
package control_switch_pkg;
  typedef enum logic [1:0] {IDLE, IN, OUT} acc_state_e;
  function automatic int dst_lo();
    return 1;
  endfunction
  function automatic int src_lo(input int dst_w);
    return 1 + dst_w;
  endfunction
  function automatic int chr_lo(input int dst_w, input int src_w);
    return 1 + dst_w + src_w;
  endfunction
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: binary code to one-hot vector
module onehot_dec #(
  parameter int W = 5
) (
  input  logic [W-1:0]    a,
  output logic [2**W-1:0] y
);
  // exactly one output line follows the input code
  always_comb begin
    y = '0;
    y[a] = 1'b1;
  end
endmodule

// File: rtl/control_switch_param.sv
// control_switch_param: serial command register, one-hot switch decode and accessory I/O sequencer; CTRL_SW_SNAPSHOT_EN adds cmd_snap/snap_vld
module control_switch_param
  import control_switch_pkg::*;
#(
  parameter int DST_W       = 5,
  parameter int SRC_W       = 5,
  parameter int CHR_W       = 2,
  parameter int DST_SPECIAL = 31,
  parameter int SRC_SPECIAL = 31,
  parameter int SRC_IN_CTL  = 12,
  parameter int SRC_OUT     = 20,
  parameter int OUT_BITS    = 29,
  parameter int MAX_WORDS   = 108,
  localparam int CMD_W      = 1 + DST_W + SRC_W + CHR_W
) (
  input  logic              CLOCK,
  input  logic              rst_n,
  input  logic              cmd_bit,
  input  logic              cmd_load,
  input  logic              cmd_shift,
  input  logic              tr,
  input  logic              pj,
  input  logic              m20,
  input  logic              ph_start,
  input  logic              ph_stop,
  input  logic              acc_in,
  output logic [CMD_W-1:0]  cmd_q,
  output logic [2**DST_W-1:0] dst_dec,
  output logic [2**SRC_W-1:0] src_dec,
  output logic              cs,
  output logic              ds,
  output logic              acc_start,
  output logic              acc_stop,
  output logic              acc_timeout,
  output logic              eb_in,
  output logic              out_shift,
  output logic              out_done,
  output logic              busy
`ifdef CTRL_SW_SNAPSHOT_EN
  ,
  output logic [CMD_W-1:0]  cmd_snap,
  output logic              snap_vld
`endif
);
  localparam int DL   = dst_lo();
  localparam int SL   = src_lo(DST_W);
  localparam int CL   = chr_lo(DST_W, SRC_W);
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam int BC_W = $clog2(OUT_BITS + 1);
  logic [DST_W-1:0] dst;
  logic [SRC_W-1:0] src;
  logic [WC_W-1:0]  wcnt;
  logic [BC_W-1:0]  bcnt;
  logic             start_req, stop_req, out_req, limit, last_bit;
  acc_state_e       state;
  assign dst       = cmd_q[DL +: DST_W];
  assign src       = cmd_q[SL +: SRC_W];
  assign cs        = cmd_q[CL + CHR_W - 1] && dst != DST_W'(DST_SPECIAL) && src != SRC_W'(SRC_SPECIAL);
  assign ds        = tr && dst == DST_W'(DST_SPECIAL);
  assign start_req = ds && src == SRC_W'(SRC_IN_CTL) && ph_start;
  assign stop_req  = ds && src == SRC_W'(SRC_IN_CTL) && ph_stop;
  assign out_req   = ds && src == SRC_W'(SRC_OUT) && pj;
  assign limit     = m20 && wcnt == WC_W'(MAX_WORDS - 1);
  assign last_bit  = bcnt == BC_W'(OUT_BITS - 1);
  assign eb_in     = acc_in && m20 && state == IN;
  assign out_shift = state == OUT && pj;
  assign out_done  = out_shift && last_bit;
  assign busy      = state != IDLE;
  onehot_dec #(.W(DST_W)) u_dst (.a(dst), .y(dst_dec));
  onehot_dec #(.W(SRC_W)) u_src (.a(src), .y(src_dec));
  // serial command entry at the MSB; a simultaneous shift moves the old MSB down
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) cmd_q <= '0;
    else begin
      if (cmd_shift) cmd_q[CMD_W-2:0] <= cmd_q[CMD_W-1:1];
      if (cmd_load) cmd_q[CMD_W-1] <= cmd_bit;
    end
  end
  // accessory sequencer: input session with word timeout, fixed-length output word
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      bcnt        <= '0;
      acc_start   <= 1'b0;
      acc_stop    <= 1'b0;
      acc_timeout <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      acc_stop  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            state       <= IN;
            wcnt        <= '0;
            acc_start   <= 1'b1;
            acc_timeout <= 1'b0;
          end else if (out_req) begin
            state <= OUT;
            bcnt  <= '0;
          end
        end
        IN: begin
          if (m20 && !limit) wcnt <= wcnt + 1'b1;
          if (stop_req || limit) begin
            state    <= IDLE;
            acc_stop <= 1'b1;
          end
          if (limit) acc_timeout <= 1'b1;
        end
        OUT: begin
          if (!pj || last_bit) state <= IDLE;
          else bcnt <= bcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CTRL_SW_SNAPSHOT_EN
  logic load_d;
  // capture the finished command word on the falling edge of cmd_load
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      load_d   <= 1'b0;
      cmd_snap <= '0;
      snap_vld <= 1'b0;
    end else begin
      load_d <= cmd_load;
      if (load_d && !cmd_load) begin
        cmd_snap <= cmd_q;
        snap_vld <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_control_switch_param.sv
// tb_control_switch_param: directed and random checks of two instances (MAX_WORDS 108 and 4) against a session-level model
module tb_control_switch_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, cmd_bit, cmd_load, cmd_shift, tr, pj, m20, ph_start, ph_stop, acc_in;
  logic [12:0] cmd_q [2];
  logic [31:0] dst_dec [2];
  logic [31:0] src_dec [2];
  logic [1:0]  cs, ds, acc_start, acc_stop, acc_timeout, eb_in, out_shift, out_done, busy;
`ifdef CTRL_SW_SNAPSHOT_EN
  logic [12:0] cmd_snap [2];
  logic [1:0]  snap_vld;
`endif
  int checks = 0, errors = 0;
  int eb_seen, osh_seen, done_seen;
  logic [12:0] m_cmd, m_snap, w_in, w_out, w;
  logic m_load_d, m_snap_vld;
  int mode [2], words [2], bits [2];
  logic sp [2], tp [2], tmo [2];
  for (genvar g = 0; g < 2; g++) begin : gi
    control_switch_param #(.MAX_WORDS(g == 0 ? 108 : 4)) u (
      .CLOCK(clk), .rst_n(rst_n), .cmd_bit(cmd_bit), .cmd_load(cmd_load), .cmd_shift(cmd_shift),
      .tr(tr), .pj(pj), .m20(m20), .ph_start(ph_start), .ph_stop(ph_stop), .acc_in(acc_in),
      .cmd_q(cmd_q[g]), .dst_dec(dst_dec[g]), .src_dec(src_dec[g]), .cs(cs[g]), .ds(ds[g]),
      .acc_start(acc_start[g]), .acc_stop(acc_stop[g]), .acc_timeout(acc_timeout[g]),
      .eb_in(eb_in[g]), .out_shift(out_shift[g]), .out_done(out_done[g]), .busy(busy[g])
`ifdef CTRL_SW_SNAPSHOT_EN
      , .cmd_snap(cmd_snap[g]), .snap_vld(snap_vld[g])
`endif
    );
  end
  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_cmd = '0; m_snap = '0; m_load_d = 1'b0; m_snap_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; words[k] = 0; bits[k] = 0; sp[k] = 1'b0; tp[k] = 1'b0; tmo[k] = 1'b0;
    end
  endtask
  // session model: mode 0 idle, 1 input session, 2 output word; words = m20 pulses seen in session
  task automatic model_edge();
    int dst = int'(m_cmd[5:1]);
    int src = int'(m_cmd[10:6]);
    bit dsm = tr && dst == 31;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_load_d && !cmd_load) begin
      m_snap = m_cmd;
      m_snap_vld = 1'b1;
    end
    m_load_d = cmd_load;
    for (int k = 0; k < 2; k++) begin
      int lim = (k == 0) ? 108 : 4;
      bit hit;
      sp[k] = 1'b0;
      tp[k] = 1'b0;
      if (mode[k] == 0) begin
        if (dsm && src == 12 && ph_start) begin
          mode[k] = 1; words[k] = 0; sp[k] = 1'b1; tmo[k] = 1'b0;
        end else if (dsm && src == 20 && pj) begin
          mode[k] = 2; bits[k] = 0;
        end
      end else if (mode[k] == 1) begin
        hit = m20 && words[k] == lim - 1;
        if (m20 && !hit) words[k]++;
        if (hit || (dsm && src == 12 && ph_stop)) begin
          mode[k] = 0; tp[k] = 1'b1;
        end
        if (hit) tmo[k] = 1'b1;
      end else begin
        if (!pj || bits[k] == 28) mode[k] = 0;
        else bits[k]++;
      end
    end
    m_cmd = {cmd_load ? cmd_bit : m_cmd[12], cmd_shift ? m_cmd[12:1] : m_cmd[11:0]};
  endtask
  task automatic check_all();
    int dst = int'(m_cmd[5:1]);
    int src = int'(m_cmd[10:6]);
    logic [31:0] edd = 32'h1 << dst;
    logic [31:0] esd = 32'h1 << src;
    bit dsm = tr && dst == 31;
    bit csm = m_cmd[12] && dst != 31 && src != 31;
    for (int k = 0; k < 2; k++) begin
      bit osh = mode[k] == 2 && pj;
      chk("cmd_q", k, 32'(cmd_q[k]), 32'(m_cmd));
      chk("dst_dec", k, dst_dec[k], edd);
      chk("src_dec", k, src_dec[k], esd);
      chk("cs", k, 32'(cs[k]), 32'(csm));
      chk("ds", k, 32'(ds[k]), 32'(dsm));
      chk("acc_start", k, 32'(acc_start[k]), 32'(sp[k]));
      chk("acc_stop", k, 32'(acc_stop[k]), 32'(tp[k]));
      chk("acc_timeout", k, 32'(acc_timeout[k]), 32'(tmo[k]));
      chk("eb_in", k, 32'(eb_in[k]), 32'(acc_in && m20 && mode[k] == 1));
      chk("out_shift", k, 32'(out_shift[k]), 32'(osh));
      chk("out_done", k, 32'(out_done[k]), 32'(osh && bits[k] == 28));
      chk("busy", k, 32'(busy[k]), 32'(mode[k] != 0));
`ifdef CTRL_SW_SNAPSHOT_EN
      chk("cmd_snap", k, 32'(cmd_snap[k]), 32'(m_snap));
      chk("snap_vld", k, 32'(snap_vld[k]), 32'(m_snap_vld));
`endif
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    eb_seen += int'(eb_in[0]);
    osh_seen += int'(out_shift[0]);
    done_seen += int'(out_done[0]);
  endtask
  task automatic areset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic load_word(input logic [12:0] v);
    for (int i = 0; i < 13; i++) begin
      cmd_bit = v[i]; cmd_load = 1'b1; cmd_shift = 1'b1;
      tick();
    end
    cmd_bit = 1'b0; cmd_load = 1'b0; cmd_shift = 1'b0;
    tick();
  endtask
  initial begin
    {cmd_bit, cmd_load, cmd_shift, tr, pj, m20, ph_start, ph_stop, acc_in} = '0;
    eb_seen = 0; osh_seen = 0; done_seen = 0;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    chk("rst_cmd_q", 0, 32'(cmd_q[0]), 32'h0);
    chk("rst_dst_dec", 0, dst_dec[0], 32'h1);
    chk("rst_src_dec", 0, src_dec[0], 32'h1);
    chk("rst_busy", 0, 32'(busy[0]), 32'h0);
    rst_n = 1'b1;
    w_in  = {2'b10, 5'd12, 5'd31, 1'b0};
    w_out = {2'b10, 5'd20, 5'd31, 1'b0};
    tr = 1'b1;
    load_word(w_in);
    chk("load_ds", 0, 32'(ds[0]), 32'h1);
    chk("load_cs", 0, 32'(cs[0]), 32'h0);
    chk("load_dst31", 0, 32'(dst_dec[0][31]), 32'h1);
    chk("load_src12", 0, 32'(src_dec[0][12]), 32'h1);
    ph_start = 1'b1; tick(); ph_start = 1'b0;
    chk("in_start", 0, 32'(acc_start[0]), 32'h1);
    chk("in_busy", 0, 32'(busy[0]), 32'h1);
    tick();
    chk("in_start_pulse", 0, 32'(acc_start[0]), 32'h0);
    eb_seen = 0; acc_in = 1'b1;
    repeat (5) begin
      m20 = 1'b1; tick(); m20 = 1'b0; tick();
    end
    acc_in = 1'b0;
    chk("eb_count", 0, 32'(eb_seen), 32'd5);
    chk("tmo_first", 1, 32'(acc_timeout[1]), 32'h1);
    ph_start = 1'b1; tick(); ph_start = 1'b0;
    chk("no_restart", 0, 32'(acc_start[0]), 32'h0);
    ph_stop = 1'b1; tick(); ph_stop = 1'b0;
    chk("in_stop", 0, 32'(acc_stop[0]), 32'h1);
    chk("in_idle", 0, 32'(busy[0]), 32'h0);
    tick();
    chk("in_stop_pulse", 0, 32'(acc_stop[0]), 32'h0);
    ph_start = 1'b1; tick(); ph_start = 1'b0;
    chk("tmo_clear", 1, 32'(acc_timeout[1]), 32'h0);
    repeat (3) begin
      m20 = 1'b1; tick(); m20 = 1'b0; tick();
    end
    chk("tmo_busy", 1, 32'(busy[1]), 32'h1);
    m20 = 1'b1; tick(); m20 = 1'b0;
    chk("tmo_stop", 1, 32'(acc_stop[1]), 32'h1);
    chk("tmo_set", 1, 32'(acc_timeout[1]), 32'h1);
    chk("tmo_idle", 1, 32'(busy[1]), 32'h0);
    tick();
    ph_stop = 1'b1; tick(); ph_stop = 1'b0;
    chk("stop_ignored", 1, 32'(acc_stop[1]), 32'h0);
    ph_start = 1'b1; tick(); ph_start = 1'b0;
    chk("tmo_clear2", 1, 32'(acc_timeout[1]), 32'h0);
    ph_stop = 1'b1; tick(); ph_stop = 1'b0;
    tick();
    load_word(w_out);
    osh_seen = 0; done_seen = 0;
    pj = 1'b1; repeat (29) tick(); pj = 1'b0; tick();
    chk("out_shifts", 0, 32'(osh_seen), 32'd29);
    chk("out_dones", 0, 32'(done_seen), 32'd1);
    chk("out_idle", 0, 32'(busy[0]), 32'h0);
    osh_seen = 0; done_seen = 0;
    pj = 1'b1; repeat (10) tick(); pj = 1'b0; tick();
    chk("abort_shifts", 0, 32'(osh_seen), 32'd10);
    chk("abort_dones", 0, 32'(done_seen), 32'd0);
    chk("abort_idle", 0, 32'(busy[0]), 32'h0);
    load_word(w_in);
    ph_start = 1'b1; tick(); ph_start = 1'b0;
    repeat (3) begin
      m20 = 1'b1; tick(); m20 = 1'b0; tick();
    end
`ifdef CTRL_SW_SNAPSHOT_EN
    chk("snap_word", 0, 32'(cmd_snap[0]), 32'(w_in));
    chk("snap_valid", 0, 32'(snap_vld[0]), 32'h1);
`endif
    areset();
    chk("rst_mid_idle", 0, 32'(busy[0]), 32'h0);
    chk("rst_mid_nostop", 0, 32'(acc_stop[0]), 32'h0);
    tick();
    chk("rst_mid_nostop2", 0, 32'(acc_stop[0]), 32'h0);
    for (int it = 0; it < 40; it++) begin
      {pj, m20, ph_start, ph_stop, acc_in} = '0;
      tr = 1'b1;
      case ($urandom_range(0, 2))
        0: w = w_in;
        1: w = w_out;
        default: w = 13'($urandom);
      endcase
      load_word(w);
      for (int c = 0; c < 50; c++) begin
        tr = $urandom_range(0, 7) != 0;
        pj = $urandom_range(0, 3) != 0;
        m20 = $urandom_range(0, 3) == 0;
        ph_start = $urandom_range(0, 7) == 0;
        ph_stop = $urandom_range(0, 7) == 0;
        acc_in = $urandom_range(0, 1) == 1;
        cmd_load = $urandom_range(0, 15) == 0;
        cmd_shift = $urandom_range(0, 15) == 0;
        cmd_bit = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 399) == 0) areset();
        else tick();
      end
      {cmd_load, cmd_shift} = '0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
